// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, flag bit positions, FSM states.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOT = 3'd4,
        OP_SHL = 3'd5,
        OP_MOV = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
// done_o is high during the cycle whose closing edge performs the final iteration,
// so product_o holds the complete product right after that edge.
module mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 kill_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 run_q, run_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;

    assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_q;

    // Next-state: load operands on start, otherwise add-and-shift while running.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (kill_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done_o) begin
                run_d = 1'b0;
            end
        end
    end

    // Control state: reset abandons any multiply in progress immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    // Datapath state: only meaningful while run_q is set, so no reset needed.
    always_ff @(posedge clk_i) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops, optional multi-cycle multiply, Z/N/C flag
// register and a registered result handed downstream through valid/ready.
module execute_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         flags_q, flags_d;

    op_e                op_w;
    logic               is_mul, can_load, accept, load_alu, load_mul, mul_start;
    logic [WIDTH:0]     sum_w, diff_w, shl_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, zn_we, c_we;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign op_w   = op_e'(op);
    assign is_mul = (MUL_EN != 0) && (op_w == OP_MUL);

    // Extra top bit captures carry, borrow, or the last bit shifted out (0 for a zero shift).
    assign sum_w  = {1'b0, src1} + {1'b0, src2};
    assign diff_w = {1'b0, src1} - {1'b0, src2};
    assign shl_w  = {1'b0, src1} << src2[SH_W-1:0];

    assign can_load  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign load_alu  = accept && !is_mul;
    assign mul_start = accept && is_mul;
    assign load_mul  = (state_q == ST_DONE) && can_load && !flush;

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk_i     (clk),
                .rst_ni    (rst_n),
                .start_i   (mul_start),
                .kill_i    (flush),
                .a_i       (src1),
                .b_i       (src2),
                .done_o    (mul_done),
                .product_o (mul_prod)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // ALU decode: result value plus which flag groups this op is allowed to write.
    always_comb begin
        alu_res = src2;
        alu_c   = flags_q[FLAG_C];
        zn_we   = 1'b1;
        c_we    = 1'b0;
        case (op_w)
            OP_ADD: begin alu_res = sum_w[WIDTH-1:0];  alu_c = sum_w[WIDTH];  c_we = 1'b1; end
            OP_SUB: begin alu_res = diff_w[WIDTH-1:0]; alu_c = diff_w[WIDTH]; c_we = 1'b1; end
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_NOT: alu_res = ~src1;
            OP_SHL: begin alu_res = shl_w[WIDTH-1:0];  alu_c = shl_w[WIDTH];  c_we = 1'b1; end
            default: begin alu_res = src2; zn_we = 1'b0; end  // MOV, and MUL when no multiplier
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_start) state_d = ST_MUL;
                ST_MUL:  if (mul_done)  state_d = ST_DONE;
                ST_DONE: if (can_load)  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: accept only when idle, the result slot frees up, and not flushing.
    always_comb begin
        in_ready = rst_n && (state_q == ST_IDLE) && can_load && !flush;
        busy     = (state_q == ST_MUL);
    end

    // Result/flag next state: a load wins over a drain; flush kills valid but keeps flags.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (load_alu) begin
                out_valid_d = 1'b1;
                result_d    = alu_res;
                if (zn_we) begin
                    flags_d[FLAG_Z] = (alu_res == '0);
                    flags_d[FLAG_N] = alu_res[WIDTH-1];
                end
                if (c_we) begin
                    flags_d[FLAG_C] = alu_c;
                end
            end else if (load_mul) begin
                out_valid_d     = 1'b1;
                result_d        = mul_prod[WIDTH-1:0];
                flags_d[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
                flags_d[FLAG_N] = mul_prod[WIDTH-1];
                flags_d[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
            end
        end
    end

    // Result, valid and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 3'b000;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit (WIDTH=16, multiplier present).
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  fl;   // {C,N,Z}
    } vec_t;

    vec_t vecs [0:13];

    execute_unit #(.WIDTH(16), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic v);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = v;
    endtask

    initial begin
        // op codes: 0 ADD 1 SUB 2 AND 3 OR 4 NOT 5 SHL 6 MOV 7 MUL
        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b101};
        vecs[1]  = '{3'd2, 16'h00F0, 16'h0F00, 16'h0000, 3'b101};
        vecs[2]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 3'b110};
        vecs[3]  = '{3'd6, 16'hAAAA, 16'h1234, 16'h1234, 3'b110};
        vecs[4]  = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 3'b100};
        vecs[5]  = '{3'd4, 16'h00FF, 16'h5555, 16'hFF00, 3'b110};
        vecs[6]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 3'b100};
        vecs[7]  = '{3'd5, 16'h1234, 16'h0000, 16'h1234, 3'b000};
        vecs[8]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b010};
        vecs[9]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b001};
        vecs[10] = '{3'd5, 16'h4000, 16'h0002, 16'h0000, 3'b101};
        vecs[11] = '{3'd5, 16'h8000, 16'h0011, 16'h0000, 3'b101};
        vecs[12] = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 3'b000};
        vecs[13] = '{3'd6, 16'hFFFF, 16'h0000, 16'h0000, 3'b000};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(3'd0, 16'h0000, 16'h0000, 1'b0);

        // Power-on reset
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU vectors, one per cycle
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i),  32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), 32'(result),    32'(vecs[i].res));
            check($sformatf("vec%0d_flags", i),  32'(flags),     32'(vecs[i].fl));
        end

        // Reset mid-traffic: asynchronous clear, held 3 cycles
        @(negedge clk);
        drive(3'd0, 16'h0001, 16'h0001, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_result", 32'(result), 32'h0002);
        @(negedge clk);
        drive(3'd1, 16'h0003, 16'h0005, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_flags", 32'(flags), 32'b110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result),    32'd0);
        check("async_rst_flags",  32'(flags),     32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);

        // Multiply 0x0100 * 0x0100, with an ADD held on the input throughout
        @(negedge clk);
        drive(3'd7, 16'h0100, 16'h0100, 1'b1);
        @(posedge clk); #1;
        check("mul_k_busy",     32'(busy),     32'd1);
        check("mul_k_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        drive(3'd0, 16'h0001, 16'h0001, 1'b1);
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            check($sformatf("mul_c%0d_busy", c),     32'(busy),      32'd1);
            check($sformatf("mul_c%0d_in_ready", c), 32'(in_ready),  32'd0);
            check($sformatf("mul_c%0d_valid", c),    32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("mul_k16_busy",     32'(busy),      32'd0);
        check("mul_k16_valid",    32'(out_valid), 32'd0);
        check("mul_k16_in_ready", 32'(in_ready),  32'd0);
        @(posedge clk); #1;
        check("mul_k17_valid",  32'(out_valid), 32'd1);
        check("mul_k17_result", 32'(result),    32'h0000);
        check("mul_k17_flags",  32'(flags),     32'b101);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mul_drain_valid",  32'(out_valid), 32'd0);
        check("mul_drain_result", 32'(result),    32'h0000);

        // Back-pressure: four ADDs, out_ready low for 3 cycles after the first
        @(negedge clk);
        drive(3'd0, 16'h0001, 16'h0001, 1'b1);
        @(posedge clk); #1;
        check("bp_r1", 32'(result), 32'h0002);
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'd0, 16'h0002, 16'h0002, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", c),    32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_result", c),   32'(result),    32'h0002);
            check($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready),  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_r2", 32'(result), 32'h0004);
        @(negedge clk);
        drive(3'd0, 16'h0003, 16'h0003, 1'b1);
        @(posedge clk); #1;
        check("bp_r3", 32'(result), 32'h0006);
        @(negedge clk);
        drive(3'd0, 16'h0004, 16'h0004, 1'b1);
        @(posedge clk); #1;
        check("bp_r4",       32'(result),    32'h0008);
        check("bp_r4_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Flush 5 cycles into a multiply
        @(negedge clk);
        drive(3'd1, 16'h0003, 16'h0005, 1'b1);
        @(posedge clk); #1;
        check("fl_pre_flags", 32'(flags), 32'b110);
        @(negedge clk);
        drive(3'd7, 16'h0003, 16'h0005, 1'b1);
        @(posedge clk); #1;
        check("fl_mul_busy", 32'(busy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("fl_c%0d_valid", c), 32'(out_valid), 32'd0);
            check($sformatf("fl_c%0d_busy", c),  32'(busy),      32'd1);
        end
        @(negedge clk);
        flush = 1'b1;
        drive(3'd0, 16'h0002, 16'h0003, 1'b1);
        #1;
        check("fl_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("fl_busy",  32'(busy),      32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_flags", 32'(flags),     32'b110);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("fl_add_valid",  32'(out_valid), 32'd1);
        check("fl_add_result", 32'(result),    32'h0005);
        check("fl_add_flags",  32'(flags),     32'b000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("fl_idle_valid", 32'(out_valid), 32'd0);
        check("fl_idle_busy",  32'(busy),      32'd0);
        check("fl_idle_result", 32'(result),   32'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
